pipe_ctrl_chain: RTL and testbench

Parametrised N-stage pipeline register and handshake chain that generalises the per-stage valid/allow_in/ready_go register update used between the IF/ID/EX/MEM/WB stages.
It owns the inter-stage valid bits and bus registers for NSTAGE stages and the inter-stage handshake.

---
 rtl/pipe_ctrl_chain_if.sv | 30 +++
 rtl/pipe_ctrl_chain.sv | 81 ++++++++
 tb/tb_pipe_ctrl_chain.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_chain_if.sv
// Handshake and bus bundle between the stage datapath logic and the pipeline register chain.
// The chain itself takes the slave view; whoever drives stage inputs takes the master view.
interface pipe_ctrl_chain_if #(
    parameter int unsigned NSTAGE = 5,
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned CNT_W  = 32
);
    logic                    in_valid;
    logic [WIDTH-1:0]        in_bus;
    logic                    in_ready;
    logic [NSTAGE-1:0]       stage_ready_go;
    logic [NSTAGE*WIDTH-1:0] stage_nxt_bus;
    logic [NSTAGE-1:0]       flush_req;
    logic [NSTAGE-1:0]       stage_valid;
    logic [NSTAGE*WIDTH-1:0] stage_bus;
    logic [NSTAGE-1:0]       stage_allow_in;
    logic                    out_valid;
    logic                    out_ready;
    logic [CNT_W-1:0]        retire_cnt;

    modport master (
        output in_valid, in_bus, stage_ready_go, stage_nxt_bus, flush_req, out_ready,
        input  in_ready, stage_valid, stage_bus, stage_allow_in, out_valid, retire_cnt
    );

    modport slave (
        input  in_valid, in_bus, stage_ready_go, stage_nxt_bus, flush_req, out_ready,
        output in_ready, stage_valid, stage_bus, stage_allow_in, out_valid, retire_cnt
    );
endinterface

// File: rtl/pipe_ctrl_chain.sv
// N-stage pipeline register chain: valid/allow_in handshake, younger-stage flush,
// output sink handshake and a wrapping retire counter.
module pipe_ctrl_chain #(
    parameter int unsigned NSTAGE = 5,
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned CNT_W  = 32
) (
    input logic              clk,
    input logic              reset,
    pipe_ctrl_chain_if.slave bus_if
);
    logic [NSTAGE-1:0]       valid_q, valid_d;
    logic [NSTAGE*WIDTH-1:0] bus_q, bus_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [NSTAGE-1:0]       allow_in;
    logic [NSTAGE-1:0]       kill;
    logic                    kill_in;
    logic                    out_valid;
    logic                    retire;

    // Both chains resolve from the oldest stage back towards the input.
    always_comb begin
        allow_in = '0;
        kill     = '0;
        allow_in[NSTAGE-1] = ~valid_q[NSTAGE-1]
                           | (bus_if.stage_ready_go[NSTAGE-1] & bus_if.out_ready);
        for (int k = NSTAGE - 2; k >= 0; k--) begin
            allow_in[k] = ~valid_q[k] | (bus_if.stage_ready_go[k] & allow_in[k+1]);
            kill[k]     = kill[k+1] | bus_if.flush_req[k+1];
        end
        kill_in = |bus_if.flush_req;
    end

    always_comb begin
        valid_d = valid_q;
        bus_d   = bus_q;
        if (allow_in[0]) begin
            valid_d[0]       = bus_if.in_valid & ~kill_in;
            bus_d[WIDTH-1:0] = bus_if.in_bus;
        end else begin
            valid_d[0] = valid_q[0] & ~kill[0];
        end
        for (int k = 1; k < NSTAGE; k++) begin
            if (allow_in[k]) begin
                valid_d[k] = valid_q[k-1] & bus_if.stage_ready_go[k-1] & ~kill[k-1];
                bus_d[k*WIDTH +: WIDTH] = bus_if.stage_nxt_bus[(k-1)*WIDTH +: WIDTH];
            end else begin
                valid_d[k] = valid_q[k] & ~kill[k];
            end
        end
    end

    assign out_valid = valid_q[NSTAGE-1] & bus_if.stage_ready_go[NSTAGE-1];
    assign retire    = out_valid & bus_if.out_ready;

    always_comb begin
        cnt_d = cnt_q;
        if (retire) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            bus_q   <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            bus_q   <= bus_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus_if.in_ready       = allow_in[0];
    assign bus_if.stage_valid    = valid_q;
    assign bus_if.stage_bus      = bus_q;
    assign bus_if.stage_allow_in = allow_in;
    assign bus_if.out_valid      = out_valid;
    assign bus_if.retire_cnt     = cnt_q;
endmodule

// File: tb/tb_pipe_ctrl_chain.sv
// Bench for pipe_ctrl_chain: item-movement reference model compared every cycle, plus
// directed scenarios with hand-computed expectations.
module tb_pipe_ctrl_chain;
    localparam int N = 5;
    localparam int W = 8;
    localparam int C = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    int   v     = 0;
    int   t_acc = 0;
    bit   chk_en = 1'b0;
    bit   acc    = 1'b0;

    // Reference model: occupancy, payload per stage, retire count.
    logic [N-1:0] mv   = '0;
    logic [W-1:0] mb [N];
    logic [W-1:0] xm [N];
    logic [C-1:0] mcnt = '0;
    logic [W-1:0] rlog [$];
    int           rcyc [$];

    pipe_ctrl_chain_if #(.NSTAGE(N), .WIDTH(W), .CNT_W(C)) pif ();

    pipe_ctrl_chain #(.NSTAGE(N), .WIDTH(W), .CNT_W(C)) dut (
        .clk    (clk),
        .reset  (reset),
        .bus_if (pif)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // A stage can take a new item if it is empty or its occupant is leaving this cycle.
    function automatic logic [N-1:0] mfree();
        logic [N-1:0] f;
        f[N-1] = !mv[N-1] || (pif.stage_ready_go[N-1] && pif.out_ready);
        for (int k = N - 2; k >= 0; k--) f[k] = !mv[k] || (pif.stage_ready_go[k] && f[k+1]);
        return f;
    endfunction

    // Items move one stage when allowed; any item that started the cycle younger than the
    // highest flushed stage (or at the input, if any flush) is dropped wherever it lands.
    function automatic void model_step();
        logic [N-1:0] f, go, nv;
        logic [W-1:0] nb [N];
        int jmax = -1;
        if (reset) begin
            mv   = '0;
            mcnt = '0;
            for (int k = 0; k < N; k++) mb[k] = '0;
            return;
        end
        f = mfree();
        for (int j = 0; j < N; j++) if (pif.flush_req[j]) jmax = j;
        for (int k = 0; k < N; k++) begin
            go[k] = mv[k] && pif.stage_ready_go[k];
            if (k == N - 1) go[k] = go[k] && pif.out_ready;
            else            go[k] = go[k] && f[k+1];
        end
        if (go[N-1]) mcnt = mcnt + 1'b1;
        if (f[0]) begin
            nv[0] = pif.in_valid && (jmax < 0);
            nb[0] = pif.in_bus;
        end else begin
            nv[0] = mv[0] && (jmax <= 0);
            nb[0] = mb[0];
        end
        for (int k = 1; k < N; k++) begin
            if (f[k]) begin
                nv[k] = go[k-1] && (k - 1 >= jmax);
                nb[k] = pif.stage_nxt_bus[(k-1)*W +: W];
            end else begin
                nv[k] = mv[k] && (k >= jmax);
                nb[k] = mb[k];
            end
        end
        mv = nv;
        for (int k = 0; k < N; k++) mb[k] = nb[k];
    endfunction

    always @(posedge clk) begin
        cyc++;
        model_step();
    end

    always @(negedge clk) begin
        if (chk_en) begin
            logic [N-1:0] f;
            f = mfree();
            chk("stage_valid", 32'(pif.stage_valid), 32'(mv));
            for (int k = 0; k < N; k++)
                if (mv[k]) chk("stage_bus", 32'(pif.stage_bus[k*W +: W]), 32'(mb[k]));
            chk("stage_allow_in", 32'(pif.stage_allow_in), 32'(f));
            chk("in_ready", 32'(pif.in_ready), 32'(f[0]));
            chk("out_valid", 32'(pif.out_valid), 32'(mv[N-1] & pif.stage_ready_go[N-1]));
            chk("retire_cnt", 32'(pif.retire_cnt), 32'(mcnt));
            if (pif.out_valid && pif.out_ready) begin
                rlog.push_back(pif.stage_bus[(N-1)*W +: W]);
                rcyc.push_back(cyc);
            end
        end
    end

    task automatic drive_nxt();
        logic [N*W-1:0] x;
        for (int k = 0; k < N; k++) x[k*W +: W] = mb[k] ^ xm[k];
        pif.stage_nxt_bus = x;
    endtask

    task automatic tick();
        #2;
        acc = pif.in_valid && pif.in_ready && (pif.flush_req == '0) && !reset;
        @(posedge clk);
        #1;
        drive_nxt();
    endtask

    task automatic idle();
        pif.in_valid       = 1'b0;
        pif.in_bus         = '0;
        pif.stage_ready_go = '1;
        pif.out_ready      = 1'b1;
        pif.flush_req      = '0;
    endtask

    task automatic drain(input int n);
        idle();
        repeat (n) tick();
    endtask

    task automatic feed_until(input int last);
        int guard = 0;
        pif.in_valid = 1'b1;
        while (v <= last && guard < 100) begin
            pif.in_bus = W'(v);
            tick();
            if (acc) v++;
            guard++;
        end
        pif.in_valid = 1'b0;
        chk("feed progress", 32'(v > last), 32'd1);
    endtask

    task automatic chk_log(input string name, input int first, input int n, input bit gap);
        chk({name, " count"}, 32'(rlog.size()), 32'(n));
        for (int i = 0; i < n && i < rlog.size(); i++) begin
            chk({name, " order"}, 32'(rlog[i]), 32'(W'(first + i)));
            if (gap && i > 0) chk({name, " gap"}, 32'(rcyc[i] - rcyc[i-1]), 32'd1);
        end
        rlog.delete();
        rcyc.delete();
    endtask

    initial begin
        for (int k = 0; k < N; k++) begin
            mb[k] = '0;
            xm[k] = '0;
        end
        idle();
        drive_nxt();

        // Reset state
        reset = 1'b1;
        tick();
        chk_en = 1'b1;
        tick();
        chk("reset valid", 32'(pif.stage_valid), 32'd0);
        chk("reset bus", 32'(pif.stage_bus), 32'd0);
        chk("reset cnt", 32'(pif.retire_cnt), 32'd0);
        chk("reset in_ready", 32'(pif.in_ready), 32'd1);
        chk("reset out_valid", 32'(pif.out_valid), 32'd0);
        reset = 1'b0;
        rlog.delete();
        rcyc.delete();

        // Streaming 0x01..0x0A: latency four edges, retire in order back to back
        v = 1;
        t_acc = cyc + 1;
        feed_until(10);
        drain(8);
        chk("latency", 32'(rcyc[0] - t_acc), 32'd4);
        chk_log("stream", 1, 10, 1'b1);
        chk("stream cnt", 32'(pif.retire_cnt), 32'd10);

        // Full pipe held by the sink for three cycles
        v = 'h21;
        feed_until('h25);
        pif.out_ready = 1'b0;
        pif.in_valid  = 1'b1;
        pif.in_bus    = W'(v);
        repeat (3) begin
            tick();
            chk("bp valid", 32'(pif.stage_valid), 32'h1f);
            chk("bp bus4", 32'(pif.stage_bus[4*W +: W]), 32'h21);
            chk("bp bus0", 32'(pif.stage_bus[0 +: W]), 32'h25);
            #1;
            chk("bp in_ready", 32'(pif.in_ready), 32'd0);
        end
        pif.out_ready = 1'b1;
        feed_until('h2a);
        drain(8);
        chk_log("backpressure", 'h21, 10, 1'b1);

        // Stage 2 not ready for two cycles: bubbles flow out from stage 3
        v = 'h31;
        feed_until('h35);
        pif.in_valid       = 1'b1;
        pif.in_bus         = W'(v);
        pif.stage_ready_go = 5'b11011;
        tick();
        chk("rg valid 1", 32'(pif.stage_valid), 32'b10111);
        chk("rg bus4", 32'(pif.stage_bus[4*W +: W]), 32'h32);
        chk("rg bus2", 32'(pif.stage_bus[2*W +: W]), 32'h33);
        #1;
        chk("rg in_ready", 32'(pif.in_ready), 32'd0);
        tick();
        chk("rg valid 2", 32'(pif.stage_valid), 32'b00111);
        chk("rg bus0", 32'(pif.stage_bus[0 +: W]), 32'h35);
        pif.stage_ready_go = '1;
        feed_until('h3a);
        drain(8);
        chk_log("ready_go", 'h31, 10, 1'b0);

        // Flush from stage 3 while everything advances
        v = 'h11;
        feed_until('h15);
        pif.flush_req = 5'b01000;
        pif.in_valid  = 1'b1;
        pif.in_bus    = 8'h16;
        tick();
        chk("flush3 valid", 32'(pif.stage_valid), 32'b10000);
        chk("flush3 bus4", 32'(pif.stage_bus[4*W +: W]), 32'h12);
        drain(8);
        chk_log("flush3", 'h11, 2, 1'b1);

        // Two flush bits: highest (stage 2) dominates, input refused
        v = 'h41;
        feed_until('h43);
        pif.flush_req = 5'b00101;
        pif.in_valid  = 1'b1;
        pif.in_bus    = 8'h44;
        tick();
        chk("flush2 valid", 32'(pif.stage_valid), 32'b01000);
        chk("flush2 bus3", 32'(pif.stage_bus[3*W +: W]), 32'h41);
        drain(8);
        chk_log("flush2", 'h41, 1, 1'b1);

        // Counter wrap: 17 retires from reset land on 1
        reset = 1'b1;
        tick();
        reset = 1'b0;
        v = 'h50;
        feed_until('h60);
        drain(8);
        chk("wrap cnt", 32'(pif.retire_cnt), 32'd1);
        chk_log("wrap", 'h50, 17, 1'b1);

        // Reset in the middle of a stream with a retire pending
        v = 'h70;
        feed_until('h75);
        pif.in_valid = 1'b1;
        pif.in_bus   = 8'h76;
        reset = 1'b1;
        tick();
        chk("midrst valid", 32'(pif.stage_valid), 32'd0);
        chk("midrst cnt", 32'(pif.retire_cnt), 32'd0);
        chk("midrst bus", 32'(pif.stage_bus), 32'd0);
        reset = 1'b0;
        drain(4);
        rlog.delete();
        rcyc.delete();

        // Randomized traffic with a non-trivial stage transform
        for (int k = 0; k < N; k++) xm[k] = W'($urandom);
        drive_nxt();
        for (int i = 0; i < 3000; i++) begin
            pif.in_valid  = ($urandom_range(0, 3) != 0);
            pif.in_bus    = W'($urandom);
            pif.out_ready = ($urandom_range(0, 3) != 0);
            for (int k = 0; k < N; k++) pif.stage_ready_go[k] = ($urandom_range(0, 3) != 0);
            pif.flush_req = ($urandom_range(0, 9) == 0) ? N'($urandom) : '0;
            reset = ($urandom_range(0, 199) == 0);
            tick();
        end
        reset = 1'b0;
        drain(10);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
